// File: rtl/uart_pkg.sv
// uart_pkg
// Shared types and constants for the UART receive path.
//   rx_state_t           : receiver FSM states (IDLE, START, DATA, STOP)
//   DEFAULT_CLKS_PER_BIT : system clocks per bit for 100 MHz / 9600 baud
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

   localparam int DEFAULT_CLKS_PER_BIT = 10417;

endpackage : uart_pkg

// File: rtl/uart_sync2.sv
// uart_sync2
// Two-flop synchroniser for a single asynchronous input. The reset value is
// a parameter so that idle-high and idle-low lines both come out of reset in
// their idle state and do not produce a spurious edge.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   line  : raw asynchronous input
//   sync  : synchronised copy of line, two clocks late
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic line,
   output logic sync
);

   logic meta;

   // The first flop may go metastable; the second gives it a full clock
   // period to resolve before anything downstream looks at it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         sync <= RESET_VAL;
      end else begin
         meta <= line;
         sync <= meta;
      end
   end

endmodule : uart_sync2

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend
// 8N1 UART receiver feeding the game clock-divert stage. rx_active rises as
// soon as a start bit is seen so the game clock freezes while a byte arrives.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   rx         : raw serial line, idles high, asynchronous to clk
//   rx_active  : high while a frame is in progress (divert request)
//   data       : last correctly framed byte, held between frames
//   data_valid : one-cycle pulse when data is updated
//   frame_err  : one-cycle pulse when the stop bit is sampled low
module uart_rx_frontend
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic                 rx_active,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_valid,
   output logic                 frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);

   // Terminal counts: a full bit period in DATA/STOP, half a bit in START so
   // that every later sample lands in the middle of its bit.
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'((CLKS_PER_BIT / 2) - 1);
   localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

   rx_state_t            state;
   logic                 syncRx;
   logic                 prevRx;
   logic [CW-1:0]        sampleCnt;
   logic [BW-1:0]        bitIdx;
   logic [DATA_BITS-1:0] shiftReg;
   logic                 fallEdge;

   uart_sync2 #(
      .RESET_VAL(1'b1)
   ) rxSync (
      .clk  (clk),
      .rst_n(rst_n),
      .line (rx),
      .sync (syncRx)
   );

   // History flop for edge detection. Preset high so a line that is already
   // idle at reset release never looks like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prevRx <= 1'b1;
      end else begin
         prevRx <= syncRx;
      end
   end

   // Only a genuine high-to-low transition arms the receiver, so a line stuck
   // low after a framing error has to go high again before a new frame.
   assign fallEdge = prevRx & ~syncRx;

   // Receiver FSM. All outputs are registered here; the pulses default low
   // every cycle so they can never stretch beyond one clock, and rx_active
   // drops on the very edge that reports the frame result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sampleCnt  <= '0;
         bitIdx     <= '0;
         shiftReg   <= '0;
         rx_active  <= 1'b0;
         data       <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (fallEdge) begin
                  state     <= START;
                  sampleCnt <= '0;
                  rx_active <= 1'b1;
               end
            end
            START: begin
               if (sampleCnt == HALF_LAST) begin
                  sampleCnt <= '0;
                  if (!syncRx) begin
                     state  <= DATA;
                     bitIdx <= '0;
                  end else begin
                     state     <= IDLE;
                     rx_active <= 1'b0;
                  end
               end else begin
                  sampleCnt <= sampleCnt + 1'b1;
               end
            end
            DATA: begin
               if (sampleCnt == BIT_LAST) begin
                  sampleCnt        <= '0;
                  shiftReg[bitIdx] <= syncRx;
                  if (bitIdx == IDX_LAST) begin
                     state <= STOP;
                  end else begin
                     bitIdx <= bitIdx + 1'b1;
                  end
               end else begin
                  sampleCnt <= sampleCnt + 1'b1;
               end
            end
            STOP: begin
               if (sampleCnt == BIT_LAST) begin
                  sampleCnt <= '0;
                  state     <= IDLE;
                  rx_active <= 1'b0;
                  if (syncRx) begin
                     data       <= shiftReg;
                     data_valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  sampleCnt <= sampleCnt + 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               rx_active <= 1'b0;
            end
         endcase
      end
   end

endmodule : uart_rx_frontend

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend
// Self-checking bench for uart_rx_frontend with CLKS_PER_BIT = 16 and
// DATA_BITS = 8. A negedge monitor logs rx_active edges and result pulses;
// each test task compares those logs against timings and bytes derived from
// the serial frames it sent.
module tb_uart_rx_frontend;

   localparam int CPB       = 16;
   localparam int DB        = 8;
   localparam int FRAME_LEN = CPB / 2 + (DB + 1) * CPB;
   localparam int RISE_LAT  = 3;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic          rx    = 1'b1;
   logic          rxActive;
   logic [DB-1:0] data;
   logic          dataValid;
   logic          frameErr;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   int            riseCycs[$];
   int            fallCycs[$];
   logic [DB-1:0] validData[$];
   int            validCycs[$];
   int            errCycs[$];
   int            bothCnt    = 0;
   logic          lastActive = 1'b0;

   always #5 clk = ~clk;

   // Number of rising edges seen so far.
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_frontend #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (DB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .rx_active (rxActive),
      .data      (data),
      .data_valid(dataValid),
      .frame_err (frameErr)
   );

   // Monitor on the falling edge, well away from the active edge.
   always @(negedge clk) begin
      if (rxActive && !lastActive) riseCycs.push_back(cyc);
      if (!rxActive && lastActive) fallCycs.push_back(cyc);
      if (dataValid) begin
         validData.push_back(data);
         validCycs.push_back(cyc);
      end
      if (frameErr) errCycs.push_back(cyc);
      if (dataValid && frameErr) bothCnt++;
      lastActive = rxActive;
   end

   task automatic clearMon();
      riseCycs.delete();
      fallCycs.delete();
      validData.delete();
      validCycs.delete();
      errCycs.delete();
      bothCnt = 0;
   endtask

   // Drive the line to v for n bit-clock cycles; returns at posedge + 1.
   task automatic drive(input logic v, input int n);
      rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Send one 8N1 frame, LSB first. startCyc is the edge count at which the
   // start bit was driven low.
   task automatic sendFrame(input logic [DB-1:0] b, input logic stopVal,
                            input int stopLen, output int startCyc);
      startCyc = cyc;
      drive(1'b0, CPB);
      for (int i = 0; i < DB; i++) drive(b[i], CPB);
      drive(stopVal, stopLen);
   endtask

   task automatic test_reset();
      $display("[TB] test_reset");
      #1 rst_n = 1'b0;
      #2;
      checks++; if (rxActive !== 1'b0) begin failures++; $display("FAIL reset_active: got %b expected 0", rxActive); end
      checks++; if (dataValid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", dataValid); end
      checks++; if (frameErr !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", frameErr); end
      checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", data); end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      clearMon();
      drive(1'b1, 200);
      checks++; if (riseCycs.size() !== 0) begin failures++; $display("FAIL idle_rise: got %0d expected 0", riseCycs.size()); end
      checks++; if (validData.size() !== 0) begin failures++; $display("FAIL idle_valid: got %0d expected 0", validData.size()); end
      checks++; if (errCycs.size() !== 0) begin failures++; $display("FAIL idle_err: got %0d expected 0", errCycs.size()); end
      checks++; if (data !== 8'h00) begin failures++; $display("FAIL idle_data: got %h expected 00", data); end
   endtask

   task automatic test_good_frame();
      int s, rise, len, vc, fc;
      logic [DB-1:0] vd;
      $display("[TB] test_good_frame");
      clearMon();
      sendFrame(8'hA5, 1'b1, CPB, s);
      drive(1'b1, 20);
      rise = (riseCycs.size() > 0) ? riseCycs[0] : -1;
      fc   = (fallCycs.size() > 0) ? fallCycs[0] : -1;
      len  = fc - rise;
      vd   = (validData.size() > 0) ? validData[0] : 8'hxx;
      vc   = (validCycs.size() > 0) ? validCycs[0] : -2;
      checks++; if (riseCycs.size() !== 1) begin failures++; $display("FAIL good_rise_count: got %0d expected 1", riseCycs.size()); end
      checks++; if (rise !== s + RISE_LAT) begin failures++; $display("FAIL good_rise_cyc: got %0d expected %0d", rise, s + RISE_LAT); end
      checks++; if (len !== FRAME_LEN) begin failures++; $display("FAIL good_active_len: got %0d expected %0d", len, FRAME_LEN); end
      checks++; if (validData.size() !== 1) begin failures++; $display("FAIL good_valid_count: got %0d expected 1", validData.size()); end
      checks++; if (vd !== 8'hA5) begin failures++; $display("FAIL good_data: got %h expected a5", vd); end
      checks++; if (vc !== fc) begin failures++; $display("FAIL good_valid_at_fall: got %0d expected %0d", vc, fc); end
      checks++; if (errCycs.size() !== 0) begin failures++; $display("FAIL good_err: got %0d expected 0", errCycs.size()); end
   endtask

   task automatic test_frame_err();
      int s, ec, fc;
      $display("[TB] test_frame_err");
      clearMon();
      sendFrame(8'h3C, 1'b0, 2 * CPB, s);
      checks++; if (riseCycs.size() !== 1) begin failures++; $display("FAIL ferr_no_rearm_low: got %0d expected 1", riseCycs.size()); end
      drive(1'b1, 20);
      ec = (errCycs.size() > 0) ? errCycs[0] : -1;
      fc = (fallCycs.size() > 0) ? fallCycs[0] : -2;
      checks++; if (errCycs.size() !== 1) begin failures++; $display("FAIL ferr_count: got %0d expected 1", errCycs.size()); end
      checks++; if (ec !== s + RISE_LAT + FRAME_LEN) begin failures++; $display("FAIL ferr_cyc: got %0d expected %0d", ec, s + RISE_LAT + FRAME_LEN); end
      checks++; if (ec !== fc) begin failures++; $display("FAIL ferr_at_fall: got %0d expected %0d", ec, fc); end
      checks++; if (validData.size() !== 0) begin failures++; $display("FAIL ferr_valid: got %0d expected 0", validData.size()); end
      checks++; if (data !== 8'hA5) begin failures++; $display("FAIL ferr_data_held: got %h expected a5", data); end
      checks++; if (riseCycs.size() !== 1) begin failures++; $display("FAIL ferr_no_rearm_high: got %0d expected 1", riseCycs.size()); end
   endtask

   task automatic test_glitch();
      int s, rise, len;
      $display("[TB] test_glitch");
      clearMon();
      s = cyc;
      drive(1'b0, 4);
      drive(1'b1, 40);
      rise = (riseCycs.size() > 0) ? riseCycs[0] : -1;
      len  = (fallCycs.size() > 0) ? fallCycs[0] - rise : -1;
      checks++; if (rise !== s + RISE_LAT) begin failures++; $display("FAIL glitch_rise: got %0d expected %0d", rise, s + RISE_LAT); end
      checks++; if (len !== CPB / 2) begin failures++; $display("FAIL glitch_len: got %0d expected %0d", len, CPB / 2); end
      checks++; if (validData.size() + errCycs.size() !== 0) begin failures++; $display("FAIL glitch_pulses: got %0d expected 0", validData.size() + errCycs.size()); end
   endtask

   task automatic test_back_to_back();
      int s1, s2, f0, r1;
      logic [DB-1:0] d0, d1;
      $display("[TB] test_back_to_back");
      clearMon();
      sendFrame(8'h00, 1'b1, CPB, s1);
      sendFrame(8'hFF, 1'b1, CPB, s2);
      drive(1'b1, 20);
      d0 = (validData.size() > 0) ? validData[0] : 8'hxx;
      d1 = (validData.size() > 1) ? validData[1] : 8'hxx;
      f0 = (fallCycs.size() > 0) ? fallCycs[0] : -1;
      r1 = (riseCycs.size() > 1) ? riseCycs[1] : -1;
      checks++; if (validData.size() !== 2) begin failures++; $display("FAIL b2b_valid_count: got %0d expected 2", validData.size()); end
      checks++; if (d0 !== 8'h00) begin failures++; $display("FAIL b2b_data0: got %h expected 00", d0); end
      checks++; if (d1 !== 8'hFF) begin failures++; $display("FAIL b2b_data1: got %h expected ff", d1); end
      checks++; if (f0 !== s1 + RISE_LAT + FRAME_LEN) begin failures++; $display("FAIL b2b_fall0: got %0d expected %0d", f0, s1 + RISE_LAT + FRAME_LEN); end
      checks++; if (r1 !== s2 + RISE_LAT) begin failures++; $display("FAIL b2b_rise1: got %0d expected %0d", r1, s2 + RISE_LAT); end
      checks++; if (!(r1 - f0 >= 1)) begin failures++; $display("FAIL b2b_gap: got %0d expected >=1", r1 - f0); end
   endtask

   task automatic test_reset_mid_frame();
      int s;
      logic [DB-1:0] b, vd;
      $display("[TB] test_reset_mid_frame");
      b = 8'h81;
      drive(1'b0, CPB);
      for (int i = 0; i < 3; i++) drive(b[i], CPB);
      drive(b[3], CPB / 2);
      checks++; if (rxActive !== 1'b1) begin failures++; $display("FAIL mid_active_before: got %b expected 1", rxActive); end
      rst_n = 1'b0;
      #2;
      checks++; if (rxActive !== 1'b0) begin failures++; $display("FAIL mid_rst_active: got %b expected 0", rxActive); end
      checks++; if (data !== 8'h00) begin failures++; $display("FAIL mid_rst_data: got %h expected 00", data); end
      checks++; if (dataValid !== 1'b0 || frameErr !== 1'b0) begin failures++; $display("FAIL mid_rst_pulses: got %b%b expected 00", dataValid, frameErr); end
      rx = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      clearMon();
      drive(1'b1, 200);
      checks++; if (validData.size() + errCycs.size() !== 0) begin failures++; $display("FAIL mid_after_pulses: got %0d expected 0", validData.size() + errCycs.size()); end
      sendFrame(b, 1'b1, CPB, s);
      drive(1'b1, 20);
      vd = (validData.size() > 0) ? validData[0] : 8'hxx;
      checks++; if (validData.size() !== 1 || vd !== 8'h81) begin failures++; $display("FAIL mid_refrm: got n=%0d d=%h expected n=1 d=81", validData.size(), vd); end
   endtask

   task automatic test_random();
      logic [DB-1:0] expQ[$];
      int            starts[$];
      int            expErr, s, gap, len, rise;
      logic [DB-1:0] b, lastGood, got;
      logic          bad;
      $display("[TB] test_random");
      clearMon();
      expErr   = 0;
      lastGood = 8'h81;
      for (int n = 0; n < 8; n++) begin
         b   = DB'($urandom_range(0, 255));
         bad = ($urandom_range(0, 3) == 0);
         gap = $urandom_range(0, 20);
         if (bad) begin
            sendFrame(b, 1'b0, CPB, s);
            drive(1'b1, gap + 2);
            expErr++;
         end else begin
            sendFrame(b, 1'b1, CPB, s);
            if (gap > 0) drive(1'b1, gap);
            expQ.push_back(b);
            lastGood = b;
         end
         starts.push_back(s);
      end
      drive(1'b1, 40);
      checks++; if (validData.size() !== expQ.size()) begin failures++; $display("FAIL rnd_valid_count: got %0d expected %0d", validData.size(), expQ.size()); end
      for (int i = 0; i < expQ.size(); i++) begin
         got = (i < validData.size()) ? validData[i] : 8'hxx;
         checks++; if (got !== expQ[i]) begin failures++; $display("FAIL rnd_data%0d: got %h expected %h", i, got, expQ[i]); end
      end
      checks++; if (errCycs.size() !== expErr) begin failures++; $display("FAIL rnd_err_count: got %0d expected %0d", errCycs.size(), expErr); end
      checks++; if (riseCycs.size() !== 8) begin failures++; $display("FAIL rnd_frames: got %0d expected 8", riseCycs.size()); end
      for (int i = 0; i < 8; i++) begin
         rise = (i < riseCycs.size()) ? riseCycs[i] : -1;
         len  = (i < fallCycs.size()) ? fallCycs[i] - rise : -1;
         checks++; if (rise !== starts[i] + RISE_LAT) begin failures++; $display("FAIL rnd_rise%0d: got %0d expected %0d", i, rise, starts[i] + RISE_LAT); end
         checks++; if (len !== FRAME_LEN) begin failures++; $display("FAIL rnd_len%0d: got %0d expected %0d", i, len, FRAME_LEN); end
      end
      checks++; if (bothCnt !== 0) begin failures++; $display("FAIL rnd_exclusive: got %0d expected 0", bothCnt); end
      checks++; if (data !== lastGood) begin failures++; $display("FAIL rnd_final_data: got %h expected %h", data, lastGood); end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_frame_err();
      test_glitch();
      test_back_to_back();
      test_reset_mid_frame();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_uart_rx_frontend

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
- 8N1 UART receiver that sits directly upstream of the game clock-divert stage.
- Synchronises the serial line, detects a start bit and immediately raises `rx_active`, which drives the divert input so the game clock is frozen while a byte arrives.
- Delivers each received byte with a one-cycle valid strobe, or flags a framing error.
- Operates entirely on the undivided system clock.

Parameters:
- CLKS_PER_BIT, 10417: system clocks per serial bit (100 MHz / 9600 baud). Legal range is ≥ 4.
- DATA_BITS, 8: payload bits per frame, sent LSB first. Legal range is 5 to 8.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- rx  input  1  raw serial line, asynchronous to clk, idles high.
- rx_active  output  1  high while a frame is in progress; this is the divert request.
- data  output  DATA_BITS  last good byte; holds its value between frames.
- data_valid  output  1  one-cycle pulse when `data` is updated.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Reset (async assert, sync-style release):
  - FSM goes to IDLE.
  - Synchroniser flops are preset to 1.
  - Bit counter and sample counter are cleared to 0.
  - Output reset values: `rx_active` = 0, `data` = 0, `data_valid` = 0, `frame_err` = 0.
  - Asserting reset mid-frame aborts the frame with no `data_valid` and no `frame_err`.
- Input conditioning:
  - 2-flop synchroniser on `rx`, followed by one history flop.
  - A falling edge is sync = 0 while prev = 1.
  - Input latency is 2 cycles.
- Counter:
  - Sample counter is $clog2(CLKS_PER_BIT) bits wide.
  - It counts up and wraps to 0 on reaching CLKS_PER_BIT-1 in DATA/STOP, or (CLKS_PER_BIT/2)-1 in START.
  - Bit index is $clog2(DATA_BITS) bits wide.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - On a falling edge: go to START, clear the counter, and set `rx_active` = 1 on the next cycle.
  - A level-low line without an edge does not start a frame. This means a line held low after a framing error waits for high before re-arming.
- START:
  - Wait CLKS_PER_BIT/2 cycles (mid start bit), then sample.
  - Sync = 0: go to DATA with bit index 0.
  - Sync = 1: false start; go to IDLE and drop `rx_active`, with no pulse.
- DATA:
  - Every CLKS_PER_BIT cycles, sample sync into shift register bit[index]; bits arrive LSB first.
  - After bit DATA_BITS-1 is sampled, go to STOP.
- STOP:
  - After CLKS_PER_BIT cycles, sample sync.
  - Sync = 1: load `data` from the shift register and pulse `data_valid` for one cycle.
  - Sync = 0: pulse `frame_err` for one cycle; `data` is unchanged.
  - Either way, go to IDLE on the same edge and drop `rx_active` on the same edge as the pulse.
- `data_valid` and `frame_err` are mutually exclusive and never held longer than one cycle.
- Frame timing: `rx_active` is high for exactly (CLKS_PER_BIT/2) + (DATA_BITS+1)·CLKS_PER_BIT cycles for a good frame.
- Back-to-back frames:
  - A new start edge arriving after the mid-stop sample is accepted normally; there is no dead time beyond returning to IDLE.
  - A start edge during the last half of the stop bit cannot occur on a legal line.
- No overrun buffering: a consumer must take `data` before the next `data_valid`.
- The downstream divert stage treats `rx_active` as its divert input. Its behaviour when `rx_active` falls is owned by that block.

Decomposition:
- Package uart_pkg:
  - enum rx_state_t {IDLE, START, DATA, STOP}
  - localparam DEFAULT_CLKS_PER_BIT = 10417
- Sub-module uart_sync2: parameterised reset value, 2-flop synchroniser. It is reused by any other async input in the design.
- All other logic stays flat in uart_rx_frontend.

Test Plan (all scenarios use CLKS_PER_BIT = 16, DATA_BITS = 8):
- Idle/reset: hold rx = 1 for 200 cycles after rst_n release -> `rx_active`, `data_valid` and `frame_err` stay 0; `data` = 0x00.
- Good frame: send 0xA5 (8N1) -> `rx_active` rises 3 cycles after the rx falling edge and stays high for 8 + 9·16 = 152 cycles. `data_valid` pulses once, with `data` = 0xA5 on the same edge that `rx_active` falls.
- Framing error: send 0x3C with the stop bit held low for 32 cycles -> `frame_err` pulses once; `data_valid` = 0; `data` keeps the previous value 0xA5. No new frame starts until rx returns high and falls again.
- Glitch rejection: pulse rx low for 4 cycles -> `rx_active` high for 8 cycles, then 0; no pulses are produced.
- Back-to-back: send 0x00 then 0xFF with no idle gap beyond the stop bit -> two `data_valid` pulses with `data` = 0x00 then 0xFF; `rx_active` drops for at least 1 cycle between the frames.
- Reset mid-frame: assert rst_n = 0 during data bit 3 of 0x81 -> all outputs are 0 asynchronously. After release with rx = 1, no `data_valid` or `frame_err` appears, and a following 0x81 is received correctly.
